// File: rtl/ext_bus_bridge_pkg.sv
// ext_bus_bridge_pkg: shared encodings for the 6502 pin bridge.
// FSM states, timeout filler data and the write pin_oe pattern.
package ext_bus_bridge_pkg;

  typedef enum logic [1:0] {
    BRG_IDLE = 2'd0,
    BRG_REQ  = 2'd1,
    BRG_DONE = 2'd2
  } brg_state_t;

  localparam logic [7:0] BRG_TIMEOUT_DATA = 8'hEA;
  localparam logic [7:0] BRG_OE_WRITE     = 8'hFF;

  function automatic logic brg_is_write(input logic [7:0] oe);
    return oe == BRG_OE_WRITE;
  endfunction

endpackage

// File: rtl/ext_bus_bridge_edge.sv
// phase_edge_detect: registers the core clk_cpu copy.
// Emits single-clk rise/fall pulses relative to the previous sample.
module phase_edge_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic i_phase,
  output logic o_rise,
  output logic o_fall
);

  logic r_phase_q;

  // previous-cycle phase sample
  always_ff @(posedge clk) begin
    if (!rst_n) r_phase_q <= 1'b0;
    else        r_phase_q <= i_phase;
  end

  assign o_rise = i_phase & ~r_phase_q;
  assign o_fall = ~i_phase & r_phase_q;

endmodule

// File: rtl/ext_bus_bridge.sv
// ext_bus_bridge: demuxes 6502 pins into a req/ack memory access.
// Define BRIDGE_TIMEOUT_EN to abort unacked accesses after TIMEOUT_CYCLES.
module ext_bus_bridge
  import ext_bus_bridge_pkg::*;
#(
  parameter int         TIMEOUT_CYCLES = 16,
  parameter logic [7:0] TIMEOUT_DATA   = BRG_TIMEOUT_DATA
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        phase,
  input  logic [7:0]  pin_ab,
  input  logic [7:0]  pin_d_out,
  input  logic [7:0]  pin_oe,
  output logic [7:0]  pin_d_in,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_we,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        bus_err,
  output logic        busy
);

  brg_state_t r_state;
  brg_state_t w_state_n;
  logic [7:0] r_addr_hi;
  logic [7:0] r_wdata;
  logic       w_rise;
  logic       w_fall;
  logic       w_issue;
  logic       w_ack_ok;
  logic       w_tmo;
  logic       w_tmo_hit;

  phase_edge_detect u_edge (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_phase(phase),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

`ifdef BRIDGE_TIMEOUT_EN
  logic [4:0] r_wait;

  // wait counter: cleared on REQ entry, counts while in REQ
  always_ff @(posedge clk) begin
    if (!rst_n)                  r_wait <= 5'd0;
    else if (w_issue)            r_wait <= 5'd0;
    else if (r_state == BRG_REQ) r_wait <= r_wait + 5'd1;
  end

  assign w_tmo_hit = (r_wait == 5'(TIMEOUT_CYCLES - 1));

  // sticky timeout flag
  always_ff @(posedge clk) begin
    if (!rst_n)     bus_err <= 1'b0;
    else if (w_tmo) bus_err <= 1'b1;
  end
`else
  logic w_unused;
  assign w_unused  = ^{TIMEOUT_DATA, 8'(TIMEOUT_CYCLES)};
  assign w_tmo_hit = 1'b0;
  assign bus_err   = 1'b0;
`endif

  // state register
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= BRG_IDLE;
    else        r_state <= w_state_n;
  end

  // next state and access strobes; ack beats timeout
  always_comb begin
    w_state_n = r_state;
    w_issue   = 1'b0;
    w_ack_ok  = 1'b0;
    w_tmo     = 1'b0;
    unique case (r_state)
      BRG_IDLE: begin
        if (w_fall) begin
          w_issue   = 1'b1;
          w_state_n = BRG_REQ;
        end
      end
      BRG_REQ: begin
        if (mem_ack) begin
          w_ack_ok  = 1'b1;
          w_state_n = BRG_DONE;
        end else if (w_tmo_hit) begin
          w_tmo     = 1'b1;
          w_state_n = BRG_DONE;
        end
      end
      BRG_DONE: begin
        if (w_rise) w_state_n = BRG_IDLE;
      end
      default: w_state_n = BRG_IDLE;
    endcase
  end

  // high-half capture; last sample before the fall wins
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_addr_hi <= 8'h00;
      r_wdata   <= 8'h00;
    end else if (phase) begin
      r_addr_hi <= pin_ab;
      r_wdata   <= pin_d_out;
    end
  end

  // memory-side outputs and read-data return
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_addr  <= 16'h0000;
      mem_wdata <= 8'h00;
      mem_we    <= 1'b0;
      mem_req   <= 1'b0;
      pin_d_in  <= 8'h00;
    end else if (w_issue) begin
      mem_addr  <= {r_addr_hi, pin_ab};
      mem_wdata <= r_wdata;
      mem_we    <= brg_is_write(pin_oe);
      mem_req   <= 1'b1;
    end else if (w_ack_ok) begin
      mem_req <= 1'b0;
      if (!mem_we) pin_d_in <= mem_rdata;
    end else if (w_tmo) begin
      mem_req <= 1'b0;
      if (!mem_we) pin_d_in <= TIMEOUT_DATA;
    end
  end

  assign busy = (r_state != BRG_IDLE);

endmodule
